// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared constants and types for the UART transmit path.
//   CLK_FREQ_HZ / BAUD : board clock and line rate
//   CLK_PER_BIT        : clock cycles per UART bit at those rates
//   FRAME_BITS         : 8N1 frame length (start + 8 data + stop)
//   arb_state_t        : arbiter FSM states
//   cnt_width()        : counter width for a given count range, never below 1
package uart_pkg;

    localparam int CLK_FREQ_HZ = 100_000_000;
    localparam int BAUD        = 115_200;
    localparam int CLK_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int FRAME_BITS  = 10;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_t;

    // $clog2 of 1 (or 0) is 0, which would yield a zero-width vector.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Byte-stream handshake between NUM_REQ message sources and the arbiter.
//   req_valid[i] : requester i offers req_data[i]
//   req_data[i]  : byte offered by requester i
//   req_last[i]  : offered byte closes the message
//   req_ready[i] : byte accepted when req_valid[i] & req_ready[i]
//   master = requester side, slave = arbiter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0] req_valid;
    logic [7:0]         req_data [NUM_REQ];
    logic [NUM_REQ-1:0] req_last;
    logic [NUM_REQ-1:0] req_ready;

    modport master (output req_valid, req_data, req_last, input req_ready);
    modport slave  (input req_valid, req_data, req_last, output req_ready);

endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Single-source 8N1 transmitter: start bit 0, data LSB first, stop bit 1,
//   each bit CLK_PER_BIT cycles. Loading in the final stop-bit cycle chains
//   the next frame with no idle bit.
//   clk, rst_n : clock, asynchronous active-low reset (tx returns to 1)
//   load       : take data into the shift register (honoured only when idle)
//   data       : byte to send
//   idle       : ready for a load (no frame, or last cycle of the stop bit)
//   tx         : UART line, idle high
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = uart_pkg::CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       idle,
    output logic       tx
);

    localparam int                BAUD_W      = cnt_width(CLK_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [3:0]        STOP_IDX    = 4'(FRAME_BITS - 1);

    logic              active;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_idx;
    logic [7:0]        shift;
    logic              tx_q;
    logic              bit_done;

    assign bit_done = (baud_cnt == '0);
    assign idle     = !active || (bit_done && bit_idx == STOP_IDX);
    assign tx       = tx_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else if (load && idle) begin
            active   <= 1'b1;
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            shift    <= data;
            tx_q     <= 1'b0;
        end else if (active) begin
            if (!bit_done) begin
                baud_cnt <= baud_cnt - BAUD_W'(1);
            end else if (bit_idx == STOP_IDX) begin
                active <= 1'b0;
            end else begin
                // Ones are shifted in behind the data, so the stop bit
                // falls out of the register after the eighth data bit.
                bit_idx  <= bit_idx + 4'd1;
                baud_cnt <= BAUD_RELOAD;
                tx_q     <= shift[0];
                shift    <= {1'b1, shift[7:1]};
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one 8N1 transmitter between NUM_REQ byte streams. The line is
//   granted round-robin per message; a granted requester keeps the line until
//   it sends a byte marked last, or stalls for LOCK_TIMEOUT idle cycles.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_if      : requester handshake (valid/data/last/ready), slave side
//   grant       : one-hot owner of the line, zero when unowned
//   busy        : a frame is being shifted out
//   timeout_err : one-cycle pulse when a stalled lock is revoked
//   tx          : UART line, idle high
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLK_PER_BIT  = uart_pkg::CLK_PER_BIT,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   req_if,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               timeout_err,
    output logic               tx
);

    localparam int               PTR_W     = cnt_width(NUM_REQ);
    localparam int               GAP_W     = cnt_width(LOCK_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_MAX   = '1;
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(LOCK_TIMEOUT);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
    logic [PTR_W-1:0]   owner, owner_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
    logic               timeout_d;
    logic               busy_d;
    logic               ser_idle;
    logic               accept;
    logic               any_valid;
    logic [PTR_W-1:0]   pick;
    int                 cand;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + PTR_W'(1);
    endfunction

    // Scan from the far end back towards rr_ptr so the last hit, which wins,
    // is the first valid requester at or after rr_ptr.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_if.req_valid[cand]) begin
                pick      = PTR_W'(cand);
                any_valid = 1'b1;
            end
        end
    end

    assign accept           = (state_q == LOCKED) && ser_idle && req_if.req_valid[owner];
    assign req_if.req_ready = (state_q == LOCKED && ser_idle) ? grant : '0;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        rr_ptr_d  = rr_ptr;
        owner_d   = owner;
        grant_d   = grant;
        gap_cnt_d = gap_cnt;
        timeout_d = 1'b0;
        busy_d    = accept ? 1'b1 : (ser_idle ? 1'b0 : busy);
        unique case (state_q)
            ARB: begin
                gap_cnt_d = '0;
                // Wait for the serializer so messages are separated by one
                // idle-high cycle on the line.
                if (any_valid && ser_idle) begin
                    state_d = LOCKED;
                    owner_d = pick;
                    grant_d = NUM_REQ'(1) << pick;
                end
            end
            LOCKED: begin
                if (accept) begin
                    gap_cnt_d = '0;
                    if (req_if.req_last[owner]) begin
                        state_d  = ARB;
                        grant_d  = '0;
                        rr_ptr_d = next_idx(owner);
                    end
                end else if (ser_idle) begin
                    // No accept while idle means the owner is stalled.
                    if (gap_cnt != GAP_MAX) begin
                        gap_cnt_d = gap_cnt + GAP_W'(1);
                    end
                    if (LOCK_TIMEOUT != 0 && gap_cnt_d == GAP_LIMIT) begin
                        state_d   = ARB;
                        grant_d   = '0;
                        rr_ptr_d  = next_idx(owner);
                        timeout_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr      <= '0;
            owner       <= '0;
            grant       <= '0;
            gap_cnt     <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr      <= rr_ptr_d;
            owner       <= owner_d;
            grant       <= grant_d;
            gap_cnt     <= gap_cnt_d;
            timeout_err <= timeout_d;
            busy        <= busy_d;
        end
    end

    uart_tx_serializer #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_serializer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (accept),
        .data (req_if.req_data[owner]),
        .idle (ser_idle),
        .tx   (tx)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (4 requesters, 8 clocks per bit,
//   lock timeout 20). A line monitor decodes frames from tx; expected bytes,
//   bit patterns and cycle offsets are written out by hand.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int CPB          = 8;
    localparam int LOCK_TIMEOUT = 20;
    localparam int FRAME        = 10 * CPB;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic               timeout_err;
    logic               tx;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) req_if ();

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .CLK_PER_BIT (CPB),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (req_if),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err),
        .tx         (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    typedef struct {
        logic [9:0] bits;   // bit k = k-th bit on the line (start first)
        int         start;  // cycle of the first start-bit cycle
    } frame_t;

    frame_t     rx_q[$];
    logic       rx_active = 1'b0;
    int         rx_cnt    = 0;
    int         rx_start  = 0;
    logic [9:0] rx_bits   = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active <= 1'b1;
                rx_cnt    <= 1;
                rx_start  <= cyc;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % CPB == CPB / 2) rx_bits[rx_cnt / CPB] <= tx;
            if (rx_cnt == FRAME - 1) begin
                rx_active <= 1'b0;
                rx_q.push_back('{bits: rx_bits, start: rx_start});
            end
        end
    end

    function automatic frame_t get_frame(input int k);
        frame_t f;
        f.bits  = '1;
        f.start = -1;
        if (k < rx_q.size()) f = rx_q[k];
        return f;
    endfunction

    task automatic check_frame(input string tag, input int k, input logic [7:0] exp_data);
        frame_t f;
        f = get_frame(k);
        check({tag, "_data"}, 32'(f.bits[8:1]), 32'(exp_data));
        check({tag, "_framing"}, 32'({f.bits[9], f.bits[0]}), 32'h2);
    endtask

    // ---------------- stimulus engine ----------------
    logic [7:0]  tab_d [NUM_REQ][8];
    logic        tab_l [NUM_REQ][8];
    int          len     [NUM_REQ];
    int          pos     [NUM_REQ];
    int          acc_cyc [NUM_REQ];
    logic [31:0] g_hist;
    int          eng_start;

    task automatic clear_tables();
        for (int i = 0; i < NUM_REQ; i++) begin
            len[i]     = 0;
            pos[i]     = 0;
            acc_cyc[i] = -1;
        end
    endtask

    task automatic add(input int i, input logic [7:0] d, input logic l);
        tab_d[i][len[i]] = d;
        tab_l[i][len[i]] = l;
        len[i]++;
    endtask

    // Drives every table concurrently until all bytes are accepted; records
    // the accept cycle per requester and the sequence of grant values.
    task automatic run_streams(input int budget, input string tag);
        int                 n;
        logic               done;
        logic [NUM_REQ-1:0] fire;
        logic [NUM_REQ-1:0] prev_grant;
        n          = 0;
        done       = 1'b0;
        prev_grant = grant;
        g_hist     = '0;
        eng_start  = cyc;
        forever begin
            if (grant !== prev_grant) begin
                g_hist     = {g_hist[27:0], 4'(grant)};
                prev_grant = grant;
            end
            done = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pos[i] < len[i]) begin
                    req_if.req_valid[i] = 1'b1;
                    req_if.req_data[i]  = tab_d[i][pos[i]];
                    req_if.req_last[i]  = tab_l[i][pos[i]];
                    done = 1'b0;
                end else begin
                    req_if.req_valid[i] = 1'b0;
                    req_if.req_last[i]  = 1'b0;
                end
            end
            if (done || n >= budget) break;
            fire = req_if.req_valid & req_if.req_ready;
            @(negedge clk);
            n++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire[i]) begin
                    acc_cyc[i] = cyc - 1;
                    pos[i]++;
                end
            end
        end
        check({tag, "_all_sent"}, 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int p;
        int n;
        frame_t f0, f1, f2, f3;

        rst_n            = 1'b0;
        req_if.req_valid = '0;
        req_if.req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) req_if.req_data[i] = 8'h00;
        clear_tables();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(req_if.req_ready), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: requester 1 sends 0x41 as a one-byte message
        rx_q.delete();
        clear_tables();
        add(1, 8'h41, 1'b1);
        run_streams(50, "t1");
        t = acc_cyc[1];
        check("t1_latency", 32'(t), 32'(eng_start + 1));
        check("t1_grant_hist", g_hist, 32'h20);
        check("t1_tx_start", 32'(tx), 32'd0);
        check("t1_busy_start", 32'(busy), 32'd1);
        while (cyc < t + FRAME) @(negedge clk);
        check("t1_busy_stop", 32'(busy), 32'd1);
        check("t1_tx_stop", 32'(tx), 32'd1);
        @(negedge clk);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_frames", 32'(rx_q.size()), 32'd1);
        f0 = get_frame(0);
        check("t1_bits", 32'(f0.bits), 32'h282);
        check("t1_frame_start", 32'(f0.start), 32'(t + 1));

        // 2: requesters 0 and 2 contend with "ab" and "cd"
        pulse_reset();
        rx_q.delete();
        clear_tables();
        add(0, 8'h61, 1'b0);
        add(0, 8'h62, 1'b1);
        add(2, 8'h63, 1'b0);
        add(2, 8'h64, 1'b1);
        run_streams(600, "t2");
        wait_idle(200, "t2");
        check("t2_frames", 32'(rx_q.size()), 32'd4);
        check_frame("t2_f0", 0, 8'h61);
        check_frame("t2_f1", 1, 8'h62);
        check_frame("t2_f2", 2, 8'h63);
        check_frame("t2_f3", 3, 8'h64);
        f0 = get_frame(0);
        f1 = get_frame(1);
        f2 = get_frame(2);
        f3 = get_frame(3);
        check("t2_gap_ab", 32'(f1.start - f0.start), 32'd80);
        check("t2_gap_bc", 32'(f2.start - f1.start), 32'd81);
        check("t2_gap_cd", 32'(f3.start - f2.start), 32'd80);
        check("t2_grant_hist", g_hist, 32'h1040);
        check("t2_rr_ptr", 32'(dut.rr_ptr), 32'd3);

        // 3: requester 3 streams one-byte messages back to back
        rx_q.delete();
        clear_tables();
        add(3, 8'h5A, 1'b1);
        add(3, 8'hA5, 1'b1);
        add(3, 8'h3C, 1'b1);
        run_streams(600, "t3");
        wait_idle(200, "t3");
        check("t3_frames", 32'(rx_q.size()), 32'd3);
        check_frame("t3_f0", 0, 8'h5A);
        check_frame("t3_f1", 1, 8'hA5);
        check_frame("t3_f2", 2, 8'h3C);
        f0 = get_frame(0);
        f1 = get_frame(1);
        f2 = get_frame(2);
        check("t3_gap_01", 32'(f1.start - f0.start), 32'd81);
        check("t3_gap_12", 32'(f2.start - f1.start), 32'd81);
        check("t3_grant_hist", g_hist, 32'h808080);

        // 4: requester 0 stalls mid-message, requester 1 waits
        rx_q.delete();
        clear_tables();
        add(0, 8'h3F, 1'b0);
        run_streams(50, "t4a");
        t = acc_cyc[0];
        req_if.req_data[1]  = 8'h77;
        req_if.req_last[1]  = 1'b1;
        req_if.req_valid[1] = 1'b1;
        n = 0;
        while (timeout_err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        p = cyc;
        check("t4_pulse_cycle", 32'(p), 32'(t + FRAME + LOCK_TIMEOUT));
        check("t4_grant_at_pulse", 32'(grant), 32'd0);
        @(negedge clk);
        check("t4_pulse_width", 32'(timeout_err), 32'd0);
        check("t4_regrant", 32'(grant), 32'h2);
        clear_tables();
        add(1, 8'h77, 1'b1);
        run_streams(50, "t4b");
        wait_idle(200, "t4");
        check("t4_frames", 32'(rx_q.size()), 32'd2);
        check_frame("t4_f0", 0, 8'h3F);
        check_frame("t4_f1", 1, 8'h77);
        check("t4_rr_ptr", 32'(dut.rr_ptr), 32'd2);

        // 5: reset in the middle of data bit 4, then a clean frame
        rx_q.delete();
        clear_tables();
        add(2, 8'hC3, 1'b0);
        run_streams(50, "t5a");
        t = acc_cyc[2];
        while (cyc < t + 5 * CPB + 4) @(negedge clk);
        check("t5_tx_bit4", 32'(tx), 32'd0);
        check("t5_grant_pre", 32'(grant), 32'h4);
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_tx_rst", 32'(tx), 32'd1);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_grant_rst", 32'(grant), 32'd0);
        check("t5_ready_rst", 32'(req_if.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rx_q.delete();
        clear_tables();
        add(0, 8'h96, 1'b1);
        run_streams(50, "t5b");
        check("t5_latency", 32'(acc_cyc[0]), 32'(eng_start + 1));
        wait_idle(200, "t5");
        check("t5_frames", 32'(rx_q.size()), 32'd1);
        f0 = get_frame(0);
        check("t5_bits", 32'(f0.bits), 32'h32C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
